dyser_cfg_loader: RTL and testbench
===================================

# dyser_cfg_loader

Configuration sequencer for the DySER fabric. On a start command it fetches `NUM_WORDS` consecutive configuration words from a word-addressed memory using a req/ack handshake. It replays each word to the fabric's `config_bits`/`config_en` inputs, one word per asserted cycle. It sits between the core's `dyser_init` path and the `dyser` instance, and holds `busy` so the send/recv issue logic stays quiet until the fabric is fully configured.

## Interface
- `NUM_WORDS`, 17: configuration words per load.
- `CFG_WIDTH`, 21: width of one configuration word.
- `ADDR_WIDTH`, 8: memory word-address width.
- `TIMEOUT`, 64: maximum cycles to wait for one `mem_ack` before error.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle load request.
- `base_addr` in `ADDR_WIDTH`: address of word 0, sampled with accepted `start`.
- `abort` in 1: cancel an in-progress load.
- `mem_req` out 1: fetch request.
- `mem_addr` out `ADDR_WIDTH`: address of the requested word.
- `mem_ack` in 1: `mem_data` valid for the current `mem_addr`.
- `mem_data` in `CFG_WIDTH`: fetched word.
- `config_bits` out `CFG_WIDTH`: word to the fabric.
- `config_en` out 1: `config_bits` valid this cycle.
- `busy` out 1: load in progress; send/recv must be held off.
- `done` out 1: one-cycle pulse, load completed.
- `err` out 1: sticky, fetch timed out.

## Operation
- States are IDLE, FETCH and ERROR. A load is accepted only in IDLE or ERROR.
- IDLE/ERROR, `start`=1, `abort`=0:
  - → FETCH.
  - Latch `base_addr`; clear word index `idx` and the watchdog.
  - Clear `err`.
- FETCH:
  - `mem_req`=1 and `mem_addr` = `base + idx`, modulo 2^`ADDR_WIDTH`, so the address wraps past all-ones to 0.
  - On `mem_ack`=1: register `mem_data` into `config_bits`, set `config_en`=1 for the next cycle, increment `idx`, clear the watchdog.
  - If the acknowledged word was index `NUM_WORDS`-1: → IDLE and set `done`=1 for the next cycle.
- Watchdog, in FETCH:
  - Increments on every cycle with `mem_ack`=0.
  - On reaching `TIMEOUT`-1 with no ack: → ERROR with `err`=1.
  - Words already emitted are not retracted.
- `abort`=1 in FETCH:
  - → IDLE with no `done` and no `err`.
  - A simultaneous `mem_ack` word is discarded: `config_en` stays 0.
- `abort` takes priority over `start` and `mem_ack`. `start` outside IDLE/ERROR is ignored.
- `busy` = (state==FETCH) | `config_en`.
- `config_bits` holds its last value when `config_en`=0.
- `idx` width is clog2(`NUM_WORDS`+1). `idx` never exceeds `NUM_WORDS`.

## Timing
- Reset (`rst`=0, asynchronous) puts the block in IDLE with all outputs 0: `mem_req`, `mem_addr`, `config_bits`, `config_en`, `busy`, `done`, `err`.
- Reset mid-load abandons the load immediately. No `done` is produced.
- Latency:
  - `start` at edge t: `mem_req`=1 and `mem_addr`=base during cycle t+1.
  - Ack sampled at edge a: `config_en`=1 during cycle a+1, and `mem_addr` advances in the same cycle.
- With `mem_ack` held high, `config_en` is high for exactly `NUM_WORDS` consecutive cycles, one word per cycle, with no bubbles.
- When acks are spaced out, `config_en` has gaps. The fabric tolerates gaps.
- `done` coincides with the last `config_en` cycle. `mem_req` drops in that same cycle.
- `busy` falls the cycle after `done`.
- A new `start` is accepted in the `done` cycle, because the state is already IDLE.
- Timeout:
  - With `mem_req` high and no ack for `TIMEOUT` cycles, `err` rises in cycle `TIMEOUT`+1 after the last ack (or after FETCH entry).
  - `mem_req` drops in the same cycle.
- Memory contract: `mem_data` must be valid during the cycle `mem_ack`=1. `mem_ack` is ignored when `mem_req`=0.

## Test plan
- **Full load, back-to-back acks:** `base_addr`=0x10, ack every cycle, `mem_data` = 0x100000 + addr → required:
  - `config_en` high for 17 consecutive cycles;
  - words 0x100010..0x100020 in order;
  - `done` pulse on the 17th;
  - `busy` low the next cycle.
- **Address wrap and sparse acks:** `base_addr`=0xF8, ack every 3rd cycle → required:
  - `mem_addr` sequence F8..FF, 00..08;
  - 17 separated `config_en` pulses;
  - a single `done`.
- **Timeout:** ack words 0–4, then withhold ack → required:
  - `err`=1 exactly 65 cycles after the 5th ack;
  - `mem_req`=0, no `done`;
  - a following `start` clears `err` and completes a normal load.
- **Abort during load:** `abort` asserted together with the ack of word 6 → required:
  - only words 0–5 emitted;
  - `config_en` stays 0 in the following cycle;
  - no `done`, `err`=0, return to IDLE.
- **Start ignored while busy:** pulse `start` with a different `base_addr` during word 8 → required: no restart, addresses continue from base+9.
- **Async reset mid-load:** drive `rst` low between clock edges at word 10 → required: all outputs 0 immediately; after release, `start` performs a clean full 17-word load.

Source files
------------

// File: rtl/dyser_cfg_loader.sv
// dyser_cfg_loader: fetches NUM_WORDS configuration words over a req/ack memory port
// and replays them to the DySER fabric, holding busy until the load completes.
module dyser_cfg_loader #(
  parameter int NUM_WORDS  = 17,
  parameter int CFG_WIDTH  = 21,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  abort_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [CFG_WIDTH-1:0]  mem_data_i,
  output logic [CFG_WIDTH-1:0]  config_bits_o,
  output logic                  config_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, ERROR} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic [WW-1:0]         wd_q;
  logic [CFG_WIDTH-1:0]  config_bits_q;
  logic                  mem_req_q;
  logic                  config_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  last_word;
  logic                  wd_expired;
  always_comb begin
    idx_d      = idx_q + IW'(1);
    last_word  = idx_q == IW'(NUM_WORDS - 1);
    wd_expired = wd_q == WW'(TIMEOUT - 1);
  end
  // busy is registered as (next state == FETCH) | (next config_en)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      mem_addr_q    <= '0;
      idx_q         <= '0;
      wd_q          <= '0;
      config_bits_q <= '0;
      mem_req_q     <= 1'b0;
      config_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      config_en_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE, ERROR: begin
          if (start_i && !abort_i) begin
            state_q    <= FETCH;
            base_q     <= base_addr_i;
            mem_addr_q <= base_addr_i;
            idx_q      <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        FETCH: begin
          if (abort_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (mem_ack_i) begin
            config_bits_q <= mem_data_i;
            config_en_q   <= 1'b1;
            busy_q        <= 1'b1;
            idx_q         <= idx_d;
            wd_q          <= '0;
            mem_addr_q    <= base_q + ADDR_WIDTH'(idx_d);
            if (last_word) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else if (wd_expired) begin
            state_q   <= ERROR;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign config_bits_o = config_bits_q;
  assign config_en_o   = config_en_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_dyser_cfg_loader.sv
// tb_dyser_cfg_loader: scoreboard bench; expected words are queued when acked and
// popped as config_en pulses appear.
module tb_dyser_cfg_loader;
  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  base_addr_i;
  logic        abort_i;
  logic        mem_req_o;
  logic [7:0]  mem_addr_o;
  logic        mem_ack_i;
  logic [20:0] mem_data_i;
  logic [20:0] config_bits_o;
  logic        config_en_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  dyser_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .abort_i(abort_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .config_bits_o(config_bits_o),
    .config_en_o(config_en_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: word at address a is 0x100000 + a
  assign mem_data_i = 21'h100000 + 21'(mem_addr_o);

  int n_chk = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];
  int en_cnt, done_cnt, run_len, max_run, since_ack;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    if (config_en_o) begin
      en_cnt++;
      run_len++;
      if (exp_q.size() == 0) chk("spurious_word", 1, 0);
      else chk("word", config_bits_o, exp_q.pop_front());
    end else begin
      run_len = 0;
    end
    if (run_len > max_run) max_run = run_len;
    if (done_o) begin
      done_cnt++;
      chk("done_with_en", config_en_o, 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic run(input logic [7:0] base, input int gap, input int nack,
                     input int abort_k, input int intr_k, input int rst_k);
    int k, cnt;
    logic [7:0] ea;
    en_cnt = 0; done_cnt = 0; run_len = 0; max_run = 0; since_ack = 0;
    exp_q.delete();
    start_i = 1'b1;
    base_addr_i = base;
    tick();
    start_i = 1'b0;
    chk("req_after_start", mem_req_o, 1);
    chk("addr_after_start", mem_addr_o, base);
    chk("err_clear_on_start", err_o, 0);
    chk("busy_after_start", busy_o, 1);
    k = 0;
    cnt = 0;
    while (mem_req_o && cnt < 400) begin
      abort_i = 1'b0;
      start_i = 1'b0;
      mem_ack_i = (k < nack) && (cnt % gap == gap - 1);
      if (mem_ack_i && k == rst_k) begin
        mem_ack_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs",
            {mem_req_o, mem_addr_o, config_bits_o, config_en_o, busy_o, done_o, err_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (mem_ack_i) begin
        ea = base + 8'(k);
        chk("addr", mem_addr_o, ea);
        if (k == abort_k) abort_i = 1'b1;
        else exp_q.push_back(21'h100000 + 21'(ea));
        if (k == intr_k) begin
          start_i = 1'b1;
          base_addr_i = base ^ 8'h55;
        end
        k++;
        since_ack = 0;
      end else begin
        since_ack++;
      end
      cnt++;
      tick();
    end
    mem_ack_i = 1'b0;
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("cycle_budget", cnt < 400, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    base_addr_i = '0;
    abort_i = 1'b0;
    mem_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {mem_req_o, mem_addr_o, config_bits_o, config_en_o, busy_o, done_o, err_o}, 0);
    rst_n = 1'b1;
    tick();

    // full load, back-to-back acks
    run(8'h10, 1, 17, -1, -1, -1);
    chk("t1_done", done_o, 1);
    chk("t1_en_on_done", config_en_o, 1);
    chk("t1_busy_on_done", busy_o, 1);
    chk("t1_words", en_cnt, 17);
    chk("t1_consecutive", max_run, 17);
    chk("t1_done_cnt", done_cnt, 1);
    tick();
    chk("t1_busy_after", busy_o, 0);
    chk("t1_done_after", done_o, 0);
    chk("t1_queue_empty", exp_q.size(), 0);

    // address wrap, sparse acks
    run(8'hF8, 3, 17, -1, -1, -1);
    repeat (3) tick();
    chk("t2_words", en_cnt, 17);
    chk("t2_separated", max_run, 1);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_busy", busy_o, 0);

    // timeout after five words, then recovery
    run(8'h40, 1, 5, -1, -1, -1);
    chk("t3_latency", since_ack, 64);
    chk("t3_err", err_o, 1);
    chk("t3_req", mem_req_o, 0);
    chk("t3_busy", busy_o, 0);
    chk("t3_words", en_cnt, 5);
    chk("t3_no_done", done_cnt, 0);
    repeat (2) tick();
    chk("t3_err_sticky", err_o, 1);
    run(8'h40, 1, 17, -1, -1, -1);
    chk("t3r_words", en_cnt, 17);
    chk("t3r_done_cnt", done_cnt, 1);
    chk("t3r_err", err_o, 0);
    tick();

    // abort together with ack of word 6
    run(8'h20, 1, 17, 6, -1, -1);
    chk("t4_en_after_abort", config_en_o, 0);
    chk("t4_req", mem_req_o, 0);
    chk("t4_busy", busy_o, 0);
    chk("t4_err", err_o, 0);
    repeat (3) tick();
    chk("t4_words", en_cnt, 6);
    chk("t4_no_done", done_cnt, 0);

    // start pulsed during word 8 is ignored
    run(8'h30, 1, 17, -1, 8, -1);
    chk("t5_words", en_cnt, 17);
    chk("t5_done_cnt", done_cnt, 1);
    tick();

    // async reset mid-load, then a clean load
    run(8'h50, 1, 17, -1, -1, 10);
    tick();
    chk("t6_idle_after_rst", {mem_req_o, config_en_o, busy_o, done_o, err_o}, 0);
    chk("t6_words", en_cnt, 10);
    chk("t6_no_done", done_cnt, 0);
    run(8'h60, 1, 17, -1, -1, -1);
    chk("t6r_words", en_cnt, 17);
    chk("t6r_done_cnt", done_cnt, 1);
    chk("t6r_consecutive", max_run, 17);
    tick();
    chk("t6r_busy_after", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
